seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the fitness timer's 4-digit common-anode seven-segment display. It consumes the 500 Hz scan clock and 1 Hz blink clock produced by the clock divider and treats both as data sampled in the `clk_in` domain, never as clocks. Each scan edge advances one digit. The block decodes BCD and drives active-low anodes and segments, with leading-zero blanking and whole-display blink.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_scan_driver_sync_edge.sv | 31 +++
 rtl/seg7_scan_driver.sv | 100 ++++++++++
 tb/tb_seg7_scan_driver.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment patterns and the BCD-to-segment decoder for the scan driver.
// Patterns are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Non-BCD nibbles show a dash so a corrupted value is visible rather than silent.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_sync_edge.sv
// Two-flop synchronizer for a slow divider output, with a registered
// one-cycle pulse on the synchronized rising edge.
module sync_edge (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise   <= sync_q & ~prev_q;
    end
  end

  assign level = sync_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: one digit per scan edge,
// frame-coherent shadow of the inputs, leading-zero blanking and blink.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic                    blink_clk,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic scan_tick;
  logic scan_level_unused;
  logic blink_lvl;
  logic blink_rise_unused;

  sync_edge u_scan_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (scan_clk),
    .level  (scan_level_unused),
    .rise   (scan_tick)
  );

  sync_edge u_blink_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (blink_clk),
    .level  (blink_lvl),
    .rise   (blink_rise_unused)
  );

  logic [IDX_W-1:0]          idx;
  logic [4*NUM_DIGITS-1:0]   sh_digits;
  logic [NUM_DIGITS-1:0]     sh_dp_en;
  logic                      sh_blank_lz;
  logic [NUM_DIGITS-1:0]     lz_mask;
  logic                      zero_run;
  logic [3:0]                cur_nib;
  logic                      cur_blank;
  logic                      blink_off;
  logic [NUM_DIGITS-1:0]     an_lit;

  // A digit is blanked only while every more-significant shadow digit is zero too.
  always_comb begin
    lz_mask  = '0;
    zero_run = sh_blank_lz;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run && (sh_digits[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_run;
    end
  end

  always_comb begin
    cur_nib   = sh_digits[4*int'(idx) +: 4];
    cur_blank = lz_mask[idx];
    blink_off = blink_en & ~blink_lvl;
    an_lit    = ~(NUM_DIGITS'(1) << idx);
  end

  // The tick cycle is a guard: all anodes off while idx moves, new digit next cycle.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      sh_digits   <= '0;
      sh_dp_en    <= '0;
      sh_blank_lz <= 1'b0;
      an          <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
    end else if (scan_tick) begin
      an <= '1;
      if (idx == IDX_LAST) begin
        idx         <= '0;
        sh_digits   <= digits;
        sh_dp_en    <= dp_en;
        sh_blank_lz <= blank_lz;
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      an  <= blink_off ? '1 : an_lit;
      seg <= cur_blank ? SEG_OFF : bcd_to_seg(cur_nib);
      dp  <= ~(sh_dp_en[idx] & ~cur_blank);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with hand-computed expected patterns.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        scan_clk;
  logic        blink_clk;
  logic [15:0] digits;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic        blink_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int total = 0;
  int bad   = 0;
  int tb_idx = 0;

  always #5 clk_in = ~clk_in;

  seg7_scan_driver #(.NUM_DIGITS(4)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .scan_clk  (scan_clk),
    .blink_clk (blink_clk),
    .digits    (digits),
    .dp_en     (dp_en),
    .blank_lz  (blank_lz),
    .blink_en  (blink_en),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // One scan step; leaves the new digit settled and idles on the low level.
  task automatic step();
    scan_clk = 1'b1;
    cyc(6);
    scan_clk = 1'b0;
    cyc(4);
    tb_idx = (tb_idx + 1) % 4;
  endtask

  task automatic goto0();
    while (tb_idx != 0) step();
  endtask

  initial begin
    reset = 1'b1; scan_clk = 1'b0; blink_clk = 1'b1;
    digits = 16'h1234; dp_en = 4'b0000; blank_lz = 1'b0; blink_en = 1'b0;
    cyc(3);
    chk("rst_an",  16'(an),  16'h000F);
    chk("rst_seg", 16'(seg), 16'h007F);
    chk("rst_dp",  16'(dp),  16'h0001);
    reset = 1'b0;
    cyc(4);
    chk("idle_an",  16'(an),  16'h000E);
    chk("idle_seg", 16'(seg), 16'(7'b1000000));

    // First frame uses zero shadows; the wrap latches 0x1234.
    step(); chk("s1_an", 16'(an), 16'h000D); chk("s1_seg", 16'(seg), 16'(7'b1000000));
    step(); chk("s2_an", 16'(an), 16'h000B);
    step(); chk("s3_an", 16'(an), 16'h0007); chk("s3_seg", 16'(seg), 16'(7'b1000000));
    step(); chk("s4_an", 16'(an), 16'h000E); chk("s4_seg", 16'(seg), 16'(7'b0011001));
    step(); chk("d1_seg", 16'(seg), 16'(7'b0110000));
    step(); chk("d2_seg", 16'(seg), 16'(7'b0100100));
    step(); chk("d3_an", 16'(an), 16'h0007); chk("d3_seg", 16'(seg), 16'(7'b1111001));
    step(); chk("d0_an", 16'(an), 16'h000E);

    // Exact guard timing: rise driven before edge k.
    scan_clk = 1'b1;
    cyc(3); chk("lat_k2_an", 16'(an), 16'h000E);
    cyc(1); chk("lat_k3_guard", 16'(an), 16'h000F);
    cyc(1); chk("lat_k4_an", 16'(an), 16'h000D); chk("lat_k4_seg", 16'(seg), 16'(7'b0110000));
    scan_clk = 1'b0;
    cyc(6); chk("fall_noeff", 16'(an), 16'h000D);
    tb_idx = 1;

    // Leading-zero blanking.
    digits = 16'h0070; blank_lz = 1'b1;
    goto0();
    chk("lz0_seg", 16'(seg), 16'(7'b1000000));
    step(); chk("lz1_seg", 16'(seg), 16'(7'b1111000));
    step(); chk("lz2_an", 16'(an), 16'h000B); chk("lz2_seg", 16'(seg), 16'h007F);
    step(); chk("lz3_an", 16'(an), 16'h0007); chk("lz3_seg", 16'(seg), 16'h007F);
    digits = 16'h0000;
    step(); chk("z0_seg", 16'(seg), 16'(7'b1000000));
    step(); chk("z1_seg", 16'(seg), 16'h007F); chk("z1_dp", 16'(dp), 16'h0001);

    // Frame coherence.
    digits = 16'h1111; blank_lz = 1'b0;
    goto0();
    step(); step();
    chk("coh2_seg", 16'(seg), 16'(7'b1111001));
    digits = 16'h2222;
    step(); chk("coh3_seg", 16'(seg), 16'(7'b1111001));
    step(); chk("coh0_seg", 16'(seg), 16'(7'b0100100));

    // Dash and decimal point.
    digits = 16'h000C; dp_en = 4'b0001;
    step(); goto0();
    chk("dash_seg", 16'(seg), 16'(7'b0111111));
    chk("dp0", 16'(dp), 16'h0000);
    step(); chk("dp1", 16'(dp), 16'h0001); chk("dp1_seg", 16'(seg), 16'(7'b1000000));

    // Blink: dark while blink_clk low, scanning continues.
    blink_en = 1'b1;
    blink_clk = 1'b0;
    cyc(2); chk("blk_k1_lit", 16'(an), 16'h000D);
    cyc(2); chk("blk_dark", 16'(an), 16'h000F);
    step(); chk("blk_step_dark", 16'(an), 16'h000F);
    blink_clk = 1'b1;
    cyc(4); chk("blk_resume", 16'(an), 16'h000B);
    blink_en = 1'b0;

    // Async reset mid-frame at idx 3.
    step();
    chk("pre_rst_an", 16'(an), 16'h0007);
    #1 reset = 1'b1;
    #1;
    chk("async_an",  16'(an),  16'h000F);
    chk("async_seg", 16'(seg), 16'h007F);
    chk("async_dp",  16'(dp),  16'h0001);
    @(negedge clk_in);
    reset = 1'b0;
    tb_idx = 0;
    cyc(3);
    chk("post_rst_an",  16'(an),  16'h000E);
    chk("post_rst_seg", 16'(seg), 16'(7'b1000000));
    step(); chk("post_rst_s1", 16'(an), 16'h000D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
